alu_sequencer: RTL
==================

# alu_sequencer

Registered command front-end for the 8-bit ALU, sitting directly upstream of it. It accepts one operation at a time over a valid/ready command port and drives the ALU operand, select and carry-in inputs from stable registers. It captures the ALU's combinational result and flags one cycle later and presents them on a valid/ready result port. It also keeps an 8-bit accumulator and a carry register, so multi-byte add chains and running computations can be sequenced without the host re-supplying operands.

## Interface
- `CNT_W`, default 16: width of the completed-operation counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 3: ALU select code (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 xnor, 110/111 illegal).
- `cmd_a` in 8: operand A.
- `cmd_b` in 8: operand B.
- `cmd_use_acc` in 1: use the accumulator as operand A instead of `cmd_a`.
- `cmd_use_carry` in 1: drive ALU `cin` from the carry register (add only); otherwise `cin`=0.
- `alu_in1`, `alu_in2` out 8: to ALU `input_1` / `input_2`.
- `alu_sel` out 3: to ALU `sel`.
- `alu_cin` out 1: to ALU `cin`.
- `alu_result` in 8: from ALU `alu_out`.
- `alu_add_ovf` in 1: from ALU adder carry/overflow output.
- `alu_ovf` in 1: from ALU `overflow_flag`.
- `alu_zero` in 1: from ALU `zero_flag`.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out 8: captured result.
- `res_ovf`, `res_zero`, `res_err` out 1: captured overflow, zero and illegal-op flags.
- `acc` out 8: accumulator value.
- `carry` out 1: carry register.
- `op_count` out CNT_W: completed operations, saturating.

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
  - IDLE: `cmd_ready`=1. When `cmd_valid`=1, latch the operands and go to EXEC.
    - `alu_in1` = `cmd_use_acc` ? `acc` : `cmd_a`.
    - `alu_in2` = `cmd_b`.
    - `alu_sel` = `cmd_op`.
    - `alu_cin` = (`cmd_use_carry` && `cmd_op`==000) ? `carry` : 0.
  - EXEC: `cmd_ready`=0. The ALU inputs are stable for the whole cycle. At the cycle end, capture `alu_result`, `alu_ovf` and `alu_zero` into the `res_*` registers and go to RESP.
    - `res_err` = (`alu_sel`[2:1]==11).
  - RESP: `res_valid`=1 and all `res_*` outputs are held stable. When `res_ready`=1, go to IDLE.
- Accumulator update, at EXEC capture:
  - Legal op: `acc` <= `alu_result`.
  - Illegal op: `acc` is unchanged.
- Carry update, at EXEC capture:
  - ADD: `carry` <= `alu_add_ovf`.
  - Every other op, including illegal ones: `carry` unchanged.
- `op_count` increments by 1 at each RESP handshake and saturates at 2^CNT_W−1.
  - Illegal ops are counted.
- The ALU inputs are registered outputs. They hold their last values in IDLE and RESP; only the EXEC cycle is meaningful.
- The block never drops a result. A new command is not accepted until the current result is consumed.

## Timing
- Reset (async assert, sync-safe deassert):
  - State = IDLE.
  - `cmd_ready`=1 from the first post-reset cycle.
  - `res_valid`=0.
  - `res_data`=0, `res_ovf`=0, `res_zero`=0, `res_err`=0.
  - `acc`=0, `carry`=0, `op_count`=0.
  - `alu_in1`=0, `alu_in2`=0, `alu_sel`=000, `alu_cin`=0.
- Latency: command accepted on edge N; result captured on edge N+1; `res_valid` high from edge N+1 onward.
- With `res_ready` tied high, throughput is one command per 3 cycles: IDLE, EXEC, RESP.
- `res_ready` asserted while `res_valid`=0 is ignored.
- `cmd_valid` in EXEC or RESP is ignored. The command must be held until `cmd_ready`.
- Reset mid-operation (EXEC or RESP) discards the in-flight result and clears `acc`, `carry` and `op_count`. No partial handshake completes.
- The wrap-around rule for `acc` follows the ALU: 8-bit modulo. Overflow is reported only via `res_ovf`.

## Test plan
- Reset then single ADD: a=0x05, b=0x03, no acc, no carry.
  - `res_valid` appears 1 cycle after accept.
  - `res_data`=0x08, `res_zero`=0, `acc`=0x08, `op_count`=1.
- Carry chain:
  - ADD a=0xFF, b=0x01 gives `res_data`=0x00, `res_zero`=1, `carry`=1.
  - Next ADD a=0x00, b=0x00 with `use_carry` gives `res_data`=0x01, `carry`=0.
- Accumulator chain: ADD 0x10+0x20, then `use_acc` SUB b=0x30.
  - `res_data`=0x00, `res_zero`=1.
  - `alu_in1` shows 0x30 during EXEC.
- Illegal op 110 with acc=0x42:
  - `res_data`=0x00, `res_err`=1, `acc` stays 0x42, `carry` unchanged, `op_count` increments.
- Backpressure: hold `res_ready`=0 for 5 cycles with `cmd_valid` held high.
  - `res_*` stable and `cmd_ready`=0 throughout.
  - Second command accepted only on the cycle after the handshake.
- Reset during RESP:
  - `res_valid` drops immediately (async).
  - `acc`=0, `op_count`=0, `cmd_ready`=1 after deassert.

Source files
------------

// File: rtl/alu_sequencer.sv
// Registered command front-end for an 8-bit ALU: accepts one operation at a time,
// drives stable ALU inputs, captures the result one cycle later and holds it until consumed.
module alu_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             cmd_use_acc,
  input  logic             cmd_use_carry,
  output logic [7:0]       alu_in1,
  output logic [7:0]       alu_in2,
  output logic [2:0]       alu_sel,
  output logic             alu_cin,
  input  logic [7:0]       alu_result,
  input  logic             alu_add_ovf,
  input  logic             alu_ovf,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_ovf,
  output logic             res_zero,
  output logic             res_err,
  output logic [7:0]       acc,
  output logic             carry,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // a producer holds valid and its payload stable until that edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state, next_state;
  logic   cmd_fire;
  logic   res_fire;
  logic   sel_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    res_valid  = 1'b0;
    cmd_fire   = 1'b0;
    res_fire   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        cmd_fire  = cmd_valid;
        if (cmd_valid) next_state = EXEC;
      end
      EXEC: begin
        next_state = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        res_fire  = res_ready;
        if (res_ready) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign state_dbg   = state;
  assign sel_illegal = (alu_sel[2:1] == 2'b11);

  // ALU inputs are latched on accept and held until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1 <= 8'h00;
      alu_in2 <= 8'h00;
      alu_sel <= 3'b000;
      alu_cin <= 1'b0;
    end else if (cmd_fire) begin
      alu_in1 <= cmd_use_acc ? acc : cmd_a;
      alu_in2 <= cmd_b;
      alu_sel <= cmd_op;
      alu_cin <= (cmd_use_carry && (cmd_op == OP_ADD)) ? carry : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= 8'h00;
      res_ovf  <= 1'b0;
      res_zero <= 1'b0;
      res_err  <= 1'b0;
      acc      <= 8'h00;
      carry    <= 1'b0;
    end else if (state == EXEC) begin
      res_data <= alu_result;
      res_ovf  <= alu_ovf;
      res_zero <= alu_zero;
      res_err  <= sel_illegal;
      if (!sel_illegal) acc <= alu_result;
      if (alu_sel == OP_ADD) carry <= alu_add_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (res_fire && (op_count != CNT_MAX)) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule
